// File: rtl/rv_pkg.sv
// Shared types and helpers for the rv memory arbiter.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    function automatic int unsigned ARB_IDX_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic              we;
        logic [XLEN/8-1:0] be;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/rv_arb_fifo.sv
// In-order FIFO of master indices used to route slave responses back to their
// requester; push and pop may occur together at any fill level, including full.
module rv_arb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = ARB_IDX_W(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push at full is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= nxt(wptr);
            end
            if (do_pop) begin
                rptr <= nxt(rptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// N-master to 1-slave req/gnt/rvalid memory arbiter with in-order response routing.
// Define RV_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned N_MASTERS       = 2,
    parameter int unsigned ADDR_W          = XLEN,
    parameter int unsigned DATA_W          = XLEN,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic [N_MASTERS-1:0]            m_req_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_be_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    output logic [N_MASTERS-1:0]            m_gnt_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_req_o,
    output logic                            s_we_o,
    output logic [DATA_W/8-1:0]             s_be_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    input  logic                            s_gnt_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic                            err_o
);

    localparam int unsigned IDX_W = ARB_IDX_W(N_MASTERS);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned XBE_W = XLEN / 8;

    mem_req_t         req_pl [N_MASTERS];
    mem_req_t         sel;
    logic [IDX_W-1:0] cand   [N_MASTERS];
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] head;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             pop;
    logic             hs;

    always_comb begin
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            req_pl[i].we    = m_we_i[i];
            req_pl[i].be    = XBE_W'(m_be_i[i*BE_W +: BE_W]);
            req_pl[i].addr  = XLEN'(m_addr_i[i*ADDR_W +: ADDR_W]);
            req_pl[i].wdata = XLEN'(m_wdata_i[i*DATA_W +: DATA_W]);
        end
    end

    // Scan masters starting at the rr pointer; first requester wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned off = 0; off < N_MASTERS; off++) begin
            cand[off] = IDX_W'((32'(rr_ptr) + off) % N_MASTERS);
            if (!any_req && m_req_i[cand[off]]) begin
                any_req = 1'b1;
                winner  = cand[off];
            end
        end
    end

    assign sel        = any_req ? req_pl[winner] : '0;
    assign s_we_o     = sel.we;
    assign s_be_o     = BE_W'(sel.be);
    assign s_addr_o   = ADDR_W'(sel.addr);
    assign s_wdata_o  = DATA_W'(sel.wdata);

    assign pop        = s_rvalid_i && !empty;
    assign s_req_o    = any_req && !(full && !pop);
    assign hs         = s_req_o && s_gnt_i;
    assign m_gnt_o    = hs  ? (N_MASTERS'(1) << winner) : '0;
    assign m_rvalid_o = pop ? (N_MASTERS'(1) << head)   : '0;
    assign m_rdata_o  = s_rdata_i;

`ifdef RV_MEM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
        end
    end
`endif

    // A response with nothing outstanding (even if a push lands this cycle) is dropped.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_o <= 1'b0;
        end else if (s_rvalid_i && empty) begin
            err_o <= 1'b1;
        end
    end

    rv_arb_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (arstn_i),
        .push  (hs),
        .pop   (pop),
        .wdata (winner),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Randomized and directed bench for rv_mem_arbiter against a queue-based reference model.
module tb_rv_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic            clk = 1'b0;
    logic            arstn;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_we;
    logic [N*BW-1:0] m_be;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_gnt;
    logic [N-1:0]    m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            s_req;
    logic            s_we;
    logic [BW-1:0]   s_be;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_gnt;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            err;

    int           vectors;
    int           miscompares;
    int           rr;
    int           oq[$];
    bit           merr;
    logic [N-1:0] last_gnt;

    always #5 clk = ~clk;

    rv_mem_arbiter #(
        .N_MASTERS       (N),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .s_req_o    (s_req),
        .s_we_o     (s_we),
        .s_be_o     (s_be),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .err_o      (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        oq.delete();
        rr       = 0;
        merr     = 1'b0;
        last_gnt = '0;
    endtask

    // Inputs are already driven; sample at the falling edge, then advance the model.
    task automatic step();
        int           w;
        int           base;
        bit           had;
        bit           pop;
        bit           sreq;
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        @(negedge clk);
        had = oq.size() > 0;
        pop = s_rvalid && had;
`ifdef RV_MEM_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = rr;
`endif
        w = -1;
        for (int off = 0; off < N; off++) begin
            if (w < 0 && m_req[(base + off) % N]) w = (base + off) % N;
        end
        sreq = (w >= 0) && !(oq.size() == MO && !pop);
        eg   = (sreq && s_gnt) ? (N'(1) << w) : '0;
        ev   = pop ? (N'(1) << oq[0]) : '0;
        check("s_req", s_req, sreq);
        check("m_gnt", m_gnt, eg);
        check("m_rvalid", m_rvalid, ev);
        check("err", err, merr);
        check("m_rdata", m_rdata, s_rdata);
        check("s_addr", s_addr, (w >= 0) ? m_addr[w*AW +: AW] : '0);
        check("s_wdata", s_wdata, (w >= 0) ? m_wdata[w*DW +: DW] : '0);
        check("s_we_be", {s_we, s_be}, (w >= 0) ? {m_we[w], m_be[w*BW +: BW]} : '0);
        if (pop) void'(oq.pop_front());
        if (s_rvalid && !had) merr = 1'b1;
        if (eg != '0) begin
            oq.push_back(w);
            rr = (w + 1) % N;
        end
        last_gnt = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req    = '0;
        m_we     = '0;
        m_be     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        arstn = 1'b1;
    endtask

    task automatic new_payload(input int i);
        m_we[i]            = 1'($urandom_range(0, 1));
        m_be[i*BW +: BW]   = BW'($urandom);
        m_addr[i*AW +: AW] = $urandom;
        m_wdata[i*DW +: DW] = $urandom;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        arstn       = 1'b0;
        idle_inputs();
        do_reset();
        step();

        // Both masters requesting, slave answers one cycle after each grant.
        for (int i = 0; i < N; i++) new_payload(i);
        m_req = 2'b11;
        s_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_rvalid = (last_gnt != '0);
            s_rdata  = $urandom;
            step();
        end
        do_reset();

        // Fill the response FIFO, stall, then pop and grant in the same cycle.
        new_payload(0);
        m_req = 2'b01;
        s_gnt = 1'b1;
        for (int k = 0; k < 3; k++) step();
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFE_0001;
        step();
        m_req = '0;
        for (int k = 0; k < 2; k++) step();
        s_rvalid = 1'b0;
        step();
        do_reset();

        // Master 1 write held while the slave withholds its grant.
        m_req                = 2'b10;
        m_we                 = 2'b10;
        m_be[BW +: BW]       = 4'b0011;
        m_addr[AW +: AW]     = 32'h0000_0100;
        m_wdata[DW +: DW]    = 32'h1234_5678;
        for (int k = 0; k < 3; k++) step();
        s_gnt = 1'b1;
        step();
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        step();
        s_rvalid = 1'b0;
        step();
        do_reset();

        // Stray response with nothing outstanding sets the sticky error.
        s_rvalid = 1'b1;
        step();
        s_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        do_reset();
        step();

        // Reset with two requests outstanding discards them.
        new_payload(0);
        new_payload(1);
        s_gnt = 1'b1;
        m_req = 2'b01;
        step();
        m_req = 2'b10;
        step();
        do_reset();
        s_rvalid = 1'b1;
        for (int k = 0; k < 2; k++) step();
        s_rvalid = 1'b0;
        new_payload(0);
        new_payload(1);
        m_req = 2'b11;
        s_gnt = 1'b1;
        step();
        do_reset();

        // Random traffic from compliant masters and a slave with random latency.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (m_req[i] && last_gnt[i]) m_req[i] = 1'b0;
                if (!m_req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        m_req[i] = 1'b1;
                        new_payload(i);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    m_req[i] = 1'b0;
                end
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            step();
        end
        m_req    = '0;
        s_gnt    = 1'b0;
        for (int k = 0; k < MO + 2; k++) begin
            s_rvalid = (oq.size() > 0);
            s_rdata  = $urandom;
            step();
        end
        s_rvalid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
